// File: rtl/shift_pkg.sv
// Shared opcode constants, op-kind enum and decode helper for the shift execute stage.
// Opcode 4'b0110 decodes as a rotate only when SHIFT_ROR_EN is defined.
package shift_pkg;

   localparam int DATA_W = 16;
   localparam int AMT_W  = 4;
   localparam int OP_W   = 4;
   localparam int RD_W   = 4;

   localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
   localparam logic [OP_W-1:0] OP_ROR = 4'b0110;

   typedef enum logic [1:0] {
      KIND_SLL     = 2'd0,
      KIND_SRA     = 2'd1,
      KIND_ROR     = 2'd2,
      KIND_ILLEGAL = 2'd3
   } op_kind_e;

   function automatic op_kind_e decode_op(input logic [OP_W-1:0] op);
      op_kind_e kind;
      kind = KIND_ILLEGAL;
      case (op)
         OP_SLL: kind = KIND_SLL;
         OP_SRA: kind = KIND_SRA;
`ifdef SHIFT_ROR_EN
         OP_ROR: kind = KIND_ROR;
`endif
         default: kind = KIND_ILLEGAL;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Handshake and result bundle between the issue logic and the shift execute stage.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface shift_exec_stage_if;
   import shift_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_opcode;
   logic [DATA_W-1:0] in_rs_data;
   logic [AMT_W-1:0]  in_imm;
   logic [RD_W-1:0]   in_rd;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [RD_W-1:0]   out_rd;
   logic              out_z;

   logic              flag_z;
   logic              err_illegal;

   modport slave (
      input  in_valid, in_opcode, in_rs_data, in_imm, in_rd, out_ready,
      output in_ready, out_valid, out_data, out_rd, out_z, flag_z, err_illegal
   );

   modport master (
      output in_valid, in_opcode, in_rs_data, in_imm, in_rd, out_ready,
      input  in_ready, out_valid, out_data, out_rd, out_z, flag_z, err_illegal
   );

endinterface

// File: rtl/Shifter.sv
// Combinational barrel shifter: mode 0 is a zero-fill left shift, mode 1 a sign-fill right shift.
module Shifter #(
   parameter int DATA_W = 16,
   parameter int AMT_W  = 4
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [AMT_W-1:0]  amt_i,
   input  logic              mode_i,
   output logic [DATA_W-1:0] data_o
);

   logic signed [DATA_W-1:0] sdata;
   logic signed [DATA_W-1:0] sra_res;
   logic        [DATA_W-1:0] sll_res;

   assign sdata   = data_i;
   assign sra_res = sdata >>> amt_i;
   assign sll_res = data_i << amt_i;
   assign data_o  = mode_i ? sra_res : sll_res;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execute stage: S1 captures the decoded operation, S2 holds the result for the consumer.
// Define SHIFT_ROR_EN to execute opcode 4'b0110 as rotate-right; otherwise it is consumed as illegal.
module shift_exec_stage
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   shift_exec_stage_if.slave bus
);

   logic              s1_valid_q, s1_valid_d;
   op_kind_e          s1_kind_q,  s1_kind_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [AMT_W-1:0]  s1_amt_q,   s1_amt_d;
   logic [RD_W-1:0]   s1_rd_q,    s1_rd_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic [RD_W-1:0]   s2_rd_q,    s2_rd_d;
   logic              s2_z_q,     s2_z_d;

   logic              flag_z_q,   flag_z_d;
   logic              err_q,      err_d;

   op_kind_e          in_kind;
   logic              legal;
   logic              s1_adv;
   logic              in_ready;
   logic              accept;
   logic [DATA_W-1:0] shf_res;
   logic [DATA_W-1:0] exec_res;

   Shifter #(
      .DATA_W (DATA_W),
      .AMT_W  (AMT_W)
   ) u_shifter (
      .data_i (s1_data_q),
      .amt_i  (s1_amt_q),
      .mode_i (s1_kind_q == KIND_SRA),
      .data_o (shf_res)
   );

`ifdef SHIFT_ROR_EN
   logic [DATA_W-1:0] ror_res;
   // Rotating a doubled word keeps the rotate a single shift of the concatenation.
   assign ror_res  = DATA_W'({s1_data_q, s1_data_q} >> s1_amt_q);
   assign exec_res = (s1_kind_q == KIND_ROR) ? ror_res : shf_res;
`else
   assign exec_res = shf_res;
`endif

   always_comb begin
      in_kind  = decode_op(bus.in_opcode);
      legal    = (in_kind != KIND_ILLEGAL);
      s1_adv   = !s2_valid_q || bus.out_ready;
      in_ready = !s1_valid_q || s1_adv;
      accept   = bus.in_valid && in_ready;

      s1_valid_d = s1_valid_q;
      s1_kind_d  = s1_kind_q;
      s1_data_d  = s1_data_q;
      s1_amt_d   = s1_amt_q;
      s1_rd_d    = s1_rd_q;
      // Illegal operations are consumed here and never occupy S1.
      if (accept && legal) begin
         s1_valid_d = 1'b1;
         s1_kind_d  = in_kind;
         s1_data_d  = bus.in_rs_data;
         s1_amt_d   = bus.in_imm;
         s1_rd_d    = bus.in_rd;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_rd_d    = s2_rd_q;
      s2_z_d     = s2_z_q;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = exec_res;
            s2_rd_d   = s1_rd_q;
            s2_z_d    = (exec_res == '0);
         end
      end

      flag_z_d = (s2_valid_q && bus.out_ready) ? s2_z_q : flag_z_q;
      err_d    = accept && !legal;
   end

   // S1 payload: qualified by s1_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      s1_kind_q <= s1_kind_d;
      s1_data_q <= s1_data_d;
      s1_amt_q  <= s1_amt_d;
      s1_rd_q   <= s1_rd_d;
   end

   // S1 valid, S2 result and architectural flag state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_rd_q    <= '0;
         s2_z_q     <= 1'b0;
         flag_z_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_rd_q    <= s2_rd_d;
         s2_z_q     <= s2_z_d;
         flag_z_q   <= flag_z_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_data    = s2_data_q;
   assign bus.out_rd      = s2_rd_q;
   assign bus.out_z       = s2_z_q;
   assign bus.flag_z      = flag_z_q;
   assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed and randomized checks of shift_exec_stage against an arithmetic reference and an in-order queue.
// Rotate expectations follow SHIFT_ROR_EN as defined for the build.
module tb_shift_exec_stage;
   import shift_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   shift_exec_stage_if bus();

   shift_exec_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] d;
      logic [3:0]  rd;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_err  = 1'b0;
   logic exp_flag = 1'b0;
   bit   last_acc;
   bit   last_hs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Result from the arithmetic meaning of each operation; bit 16 flags a legal opcode.
   function automatic logic [16:0] ref_op(input logic [3:0] op, input logic [15:0] a, input logic [3:0] s);
      longint p, v, r, ua;
      p = 1;
      for (int i = 0; i < int'(s); i++) p = p * 2;
      ua = longint'(a);
      case (op)
         4'b0100: return {1'b1, 16'((ua * p) % 65536)};
         4'b0101: begin
            v = a[15] ? ua - 65536 : ua;
            r = v / p;
            if (v < 0 && (v % p) != 0) r = r - 1;
            return {1'b1, 16'((r + 65536) % 65536)};
         end
`ifdef SHIFT_ROR_EN
         4'b0110: return {1'b1, 16'((ua / p) + (ua % p) * (65536 / p))};
`endif
         default: return 17'h0;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] d,
                        input logic [3:0] imm, input logic [3:0] rd);
      bus.in_valid   = v;
      bus.in_opcode  = op;
      bus.in_rs_data = d;
      bus.in_imm     = imm;
      bus.in_rd      = rd;
   endtask

   // One clock: check at the falling edge, advance the model for the coming rising edge.
   task automatic cycle();
      exp_t e;
      logic [16:0] r;
      @(negedge clk);
      check("in_ready", bus.in_ready, (q.size() < 2) ? 32'd1 : 32'(bus.out_ready));
      check("err_illegal", bus.err_illegal, exp_err);
      check("flag_z", bus.flag_z, exp_flag);
      if (q.size() == 2) check("out_valid_full", bus.out_valid, 1);
      if (q.size() == 0) check("out_valid_empty", bus.out_valid, 0);
      if (bus.out_valid && q.size() > 0) begin
         check("out_data", bus.out_data, q[0].d);
         check("out_rd", bus.out_rd, q[0].rd);
         check("out_z", bus.out_z, q[0].d == 16'h0);
      end
      last_acc = bus.in_valid && bus.in_ready;
      last_hs  = bus.out_valid && bus.out_ready;
      exp_err  = 1'b0;
      if (last_hs && q.size() > 0) begin
         e = q.pop_front();
         exp_flag = (e.d == 16'h0);
      end
      if (last_acc) begin
         r = ref_op(bus.in_opcode, bus.in_rs_data, bus.in_imm);
         if (r[16]) q.push_back('{r[15:0], bus.in_rd});
         else exp_err = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      bit acc;
      logic [3:0] op;
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      bus.out_ready = 1'b1;
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_rd", bus.out_rd, 0);
      check("rst_out_z", bus.out_z, 0);
      check("rst_flag_z", bus.flag_z, 0);
      check("rst_err", bus.err_illegal, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("ready_after_rst", bus.in_ready, 1);

      // SLL latency
      drive(1'b1, OP_SLL, 16'h0001, 4'd3, 4'h5);
      cycle();
      check("sll_not_yet", bus.out_valid, 0);
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      cycle();
      check("sll_valid", bus.out_valid, 1);
      check("sll_data", bus.out_data, 16'h0008);
      check("sll_rd", bus.out_rd, 4'h5);
      check("sll_z", bus.out_z, 0);

      // SRA sign fill and zero result
      drive(1'b1, OP_SRA, 16'h8000, 4'd3, 4'h1);
      cycle();
      drive(1'b1, OP_SRA, 16'h0001, 4'd1, 4'h2);
      cycle();
      check("sra_neg", bus.out_data, 16'hF000);
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      cycle();
      check("sra_zero", bus.out_data, 16'h0000);
      check("sra_zero_z", bus.out_z, 1);
      check("sra_zero_rd", bus.out_rd, 4'h2);
      cycle();
      check("sra_flag_z", bus.flag_z, 1);

      // Backpressure with three back-to-back operations
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SLL, 16'h0003, 4'd2, 4'hA);
      cycle();
      drive(1'b1, OP_SRA, 16'hF0F0, 4'd4, 4'hB);
      cycle();
      drive(1'b1, OP_SLL, 16'h1234, 4'd0, 4'hC);
      check("bp_ready_low", bus.in_ready, 0);
      repeat (3) begin
         cycle();
         check("bp_hold_data", bus.out_data, 16'h000C);
         check("bp_hold_rd", bus.out_rd, 4'hA);
         check("bp_ready_held", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         cycle();
         acc = last_acc;
      end
      check("bp_third_accepted", acc, 1);
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      drain();

      // Rotate (or illegal without the rotate option) with flag_z set beforehand
      drive(1'b1, OP_SLL, 16'h0000, 4'd0, 4'h3);
      cycle();
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      repeat (3) cycle();
      check("pre_ror_flag", bus.flag_z, 1);
      drive(1'b1, OP_ROR, 16'h0001, 4'd1, 4'h7);
      cycle();
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
`ifdef SHIFT_ROR_EN
      check("ror_no_err", bus.err_illegal, 0);
      cycle();
      check("ror_valid", bus.out_valid, 1);
      check("ror_data", bus.out_data, 16'h8000);
      check("ror_rd", bus.out_rd, 4'h7);
      drain();
`else
      check("ror_err", bus.err_illegal, 1);
      cycle();
      check("ror_err_pulse", bus.err_illegal, 0);
      check("ror_no_valid", bus.out_valid, 0);
      check("ror_flag_kept", bus.flag_z, 1);
      cycle();
      check("ror_no_valid2", bus.out_valid, 0);
`endif

      // Illegal opcode while a legal op is in flight
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SLL, 16'h00FF, 4'd4, 4'h9);
      cycle();
      drive(1'b1, 4'hF, 16'hDEAD, 4'd2, 4'h1);
      cycle();
      check("ill_err", bus.err_illegal, 1);
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      cycle();
      check("ill_err_pulse", bus.err_illegal, 0);
      check("ill_valid", bus.out_valid, 1);
      check("ill_data", bus.out_data, 16'h0FF0);
      check("ill_rd", bus.out_rd, 4'h9);
      bus.out_ready = 1'b1;
      drain();
      cycle();
      check("ill_no_extra", bus.out_valid, 0);

      // Asynchronous reset with two operations in flight
      drive(1'b1, OP_SLL, 16'h8000, 4'd1, 4'h2);
      cycle();
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      repeat (3) cycle();
      check("pre_rst_flag", bus.flag_z, 1);
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SLL, 16'h0101, 4'd1, 4'h4);
      cycle();
      drive(1'b1, OP_SRA, 16'h4000, 4'd2, 4'h6);
      cycle();
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      check("pre_rst_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_flag_z", bus.flag_z, 0);
      check("arst_out_data", bus.out_data, 0);
      check("arst_out_rd", bus.out_rd, 0);
      q.delete();
      exp_flag = 1'b0;
      exp_err  = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      check("arst_ready", bus.in_ready, 1);
      cycle();
      check("arst_discarded", bus.out_valid, 0);

      // Randomized traffic against the queue model
      repeat (400) begin
         case ($urandom_range(0, 9))
            0, 1, 2: op = OP_SLL;
            3, 4, 5: op = OP_SRA;
            6, 7:    op = OP_ROR;
            default: op = 4'($urandom_range(0, 15));
         endcase
         drive($urandom_range(0, 3) != 0, op,
               ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drive(1'b0, 4'h0, 16'h0, 4'h0, 4'h0);
      bus.out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port in_valid, input, 1, upstream operation valid.
REQ-004 SHALL provide port in_ready, output, 1, stage can accept an operation this cycle.
REQ-005 SHALL provide port in_opcode, input, 4, operation code.
REQ-006 SHALL provide port in_rs_data, input, 16, source operand.
REQ-007 SHALL provide port in_imm, input, 4, shift amount 0..15.
REQ-008 SHALL provide port in_rd, input, 4, destination register tag, carried unchanged.
REQ-009 SHALL provide port out_valid, output, 1, result valid.
REQ-010 SHALL provide port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL provide port out_data, output, 16, shift result.
REQ-012 SHALL provide port out_rd, output, 4, destination tag of the result.
REQ-013 SHALL provide port out_z, output, 1, result-is-zero indication for out_data.
REQ-014 SHALL provide port flag_z, output, 1, architectural Z flag register.
REQ-015 SHALL provide port err_illegal, output, 1, one-cycle pulse on an accepted illegal opcode.

Function
REQ-016 SHALL decode opcodes: 4'b0100 SLL, 4'b0101 SRA, 4'b0110 ROR (when enabled); all other opcodes are illegal.
REQ-017 SHALL accept an operation when in_valid && in_ready; that is the only accept condition.
REQ-018 SHALL be a two-stage pipeline: S1 registers opcode/operand/amount/tag; S2 registers the computed result, tag and zero bit.
REQ-019 SHALL assert out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-020 SHALL drive in_ready = !s1_valid || (s1 can advance), where S1 advances when !s2_valid || out_ready.
REQ-021 SHALL sustain one operation per cycle with out_ready high.
REQ-022 SHALL hold out_data, out_rd and out_z stable while out_valid && !out_ready.
REQ-023 SHALL never drop, duplicate or reorder legal operations; capacity is 2 in flight.
REQ-024 SHALL compute SLL as zero-fill left shift, SRA as sign-fill right shift, and ROR as right rotate, each by in_imm; an amount of 0 passes the operand unchanged.
REQ-025 SHALL set out_z = (out_data == 16'h0000).
REQ-026 SHALL load flag_z from out_z only on an output handshake (out_valid && out_ready); it holds otherwise.
REQ-027 SHALL accept illegal opcodes (consume them), not insert them into S1, and pulse err_illegal for one cycle after the accepting edge.

Reset
REQ-028 SHALL, while rst_n is low, force s1_valid=0, s2_valid=0, out_valid=0, out_data=16'h0000, out_rd=4'h0, out_z=0, flag_z=0 and err_illegal=0, regardless of clk.
REQ-029 SHALL discard all in-flight operations on reset, and SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, when SHIFT_ROR_EN is defined, execute opcode 4'b0110 as a rotate right.
REQ-031 SHALL, when SHIFT_ROR_EN is undefined, treat 4'b0110 as illegal per REQ-027 and contain no rotate logic.

Structure
REQ-032 SHALL take its opcode constants and the op-kind enum (SLL/SRA/ROR/ILLEGAL) from shared package shift_pkg.
REQ-033 SHALL instantiate the existing Shifter as the sole sub-module for SLL/SRA between S1 and S2, with Mode 0 for SLL and Mode 1 for SRA; ROR is local logic.

Verification
REQ-034 SHALL cover: SLL, 0x0001, amount 3 -> out_data 0x0008 two cycles later, out_z=0.
REQ-035 SHALL cover: SRA, 0x8000, amount 3 -> 0xF000; then SRA, 0x0001, amount 1 -> 0x0000, out_z=1, and flag_z=1 after the handshake.
REQ-036 SHALL cover: three back-to-back ops with out_ready=0 -> in_ready low after 2 accepts, outputs held stable; release out_ready -> all three emerge in order with correct rd tags.
REQ-037 SHALL cover: ROR, 0x0001, amount 1 -> 0x8000 with SHIFT_ROR_EN; without it -> err_illegal pulse, no out_valid, flag_z unchanged.
REQ-038 SHALL cover: opcode 4'b1111 accepted -> err_illegal pulse, pipeline contents unaffected.
REQ-039 SHALL cover: rst_n low with 2 ops in flight -> out_valid=0 and flag_z=0 immediately (asynchronously), in_ready=1 in the first cycle after release.
